// File: rtl/nco_wave.sv
// nco_wave: waveform stage downstream of the phase-accumulator NCO.
//
// Samples the NCO phase on each ena strobe and converts it into an unsigned
// offset-binary DAC code. Waveform select and pulse width are latched only on
// a phase wrap, so a running cycle is never switched mid-way.
//
// Parameters:
//   dsz  phase input width (must match the NCO accumulator width)
//   osz  output/DAC word width, 8 <= osz <= dsz
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   ena       sample strobe (phs is valid in the same cycle)
//   phs       NCO phase accumulator value
//   wave_sel  requested waveform, applied at the next wrap
//                0 saw, 1 inverse saw, 2 triangle, 3 pulse,
//                4 sub square, 5 sub-2 square, 6 noise, 7 saw+sub mix
//   pw        pulse width for wave_sel 3, applied at the next wrap
//   out       registered waveform sample
//   valid     one-clk pulse when out updates (two clocks after ena)
//   sub       sub-octave square (toggles on every phase wrap)
//
// Build option:
//   NCO_WAVE_NOISE_EN  when defined, wave_sel 6 outputs a 23-bit LFSR
//                      (x^23 + x^18 + 1); otherwise wave_sel 6 is a saw.

module nco_wave #(
  parameter int unsigned dsz = 24,
  parameter int unsigned osz = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic [dsz-1:0] phs,
  input  logic [2:0]     wave_sel,
  input  logic [7:0]     pw,
  output logic [osz-1:0] out,
  output logic           valid,
  output logic           sub
);

  localparam int unsigned pw_w  = 8;
  localparam int unsigned sel_w = 3;

  localparam logic [osz-1:0] out_mid = {1'b1, {(osz-1){1'b0}}};
  localparam logic [osz-1:0] out_max = {osz{1'b1}};
  localparam logic [osz-1:0] out_zero = {osz{1'b0}};

  localparam logic [sel_w-1:0] sel_saw   = 3'd0;
  localparam logic [sel_w-1:0] sel_isaw  = 3'd1;
  localparam logic [sel_w-1:0] sel_tri   = 3'd2;
  localparam logic [sel_w-1:0] sel_pulse = 3'd3;
  localparam logic [sel_w-1:0] sel_sub   = 3'd4;
  localparam logic [sel_w-1:0] sel_sub2  = 3'd5;
  localparam logic [sel_w-1:0] sel_noise = 3'd6;
  localparam logic [sel_w-1:0] sel_mix   = 3'd7;

  // Elaboration-time parameter sanity check.
  if (osz < 8 || osz > dsz) begin : g_bad_osz
    $error("nco_wave: osz must satisfy 8 <= osz <= dsz");
  end

  // Stage-1 state
  logic [dsz-1:0]   phs_prev;
  logic [osz-1:0]   p1;
  logic             v1;
  logic [sel_w-1:0] sel_q;
  logic [pw_w-1:0]  pw_q;
  logic             sub2;

  // Combinational helpers
  logic             wrap_c;
  logic [osz-1:0]   tri_c;
  logic [osz-1:0]   noise_c;
  logic [osz-1:0]   wave_c;

  // A wrap is a strict decrease of phase between consecutive samples; equal
  // phases (frq = 0) never wrap, and at most one wrap is seen per sample.
  assign wrap_c = (phs < phs_prev);

  // Stage 1: capture phase, detect wrap, latch per-cycle controls on wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      phs_prev <= '0;
      p1       <= '0;
      v1       <= 1'b0;
      sel_q    <= '0;
      pw_q     <= '0;
      sub      <= 1'b0;
      sub2     <= 1'b0;
    end else if (ena) begin
      phs_prev <= phs;
      p1       <= phs[dsz-1 -: osz];
      v1       <= 1'b1;
      if (wrap_c) begin
        sub   <= ~sub;
        sel_q <= wave_sel;
        pw_q  <= pw;
        // sub2 advances on the falling edge of sub (sub currently 1).
        if (sub) begin
          sub2 <= ~sub2;
        end
      end
    end else begin
      v1 <= 1'b0;
    end
  end

`ifdef NCO_WAVE_NOISE_EN
  localparam int unsigned lfsr_w = 23;

  if (osz > lfsr_w) begin : g_bad_noise_osz
    $error("nco_wave: noise option needs osz <= 23");
  end

  logic [lfsr_w-1:0] lfsr;

  // Fibonacci LFSR x^23 + x^18 + 1, one step per sample strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= lfsr_w'(1);
    end else if (ena) begin
      lfsr <= {lfsr[lfsr_w-2:0], lfsr[22] ^ lfsr[17]};
    end
  end

  assign noise_c = lfsr[lfsr_w-1 -: osz];
`else
  // Without the noise option, sel 6 is an ordinary saw.
  assign noise_c = p1;
`endif

  // Triangle: fold the phase at midscale using the lower osz-1 bits doubled.
  assign tri_c = {p1[osz-2:0], 1'b0};

  // Stage-2 waveform function.
  always_comb begin
    wave_c = p1;
    case (sel_q)
      sel_saw:   wave_c = p1;
      sel_isaw:  wave_c = ~p1;
      sel_tri:   wave_c = p1[osz-1] ? ~tri_c : tri_c;
      sel_pulse: wave_c = (p1[osz-1 -: pw_w] < pw_q) ? out_max : out_zero;
      sel_sub:   wave_c = sub ? out_max : out_zero;
      sel_sub2:  wave_c = sub2 ? out_max : out_zero;
      sel_noise: wave_c = noise_c;
      // (p1 >> 1) tops out at out_mid-1, so adding out_mid cannot overflow.
      sel_mix:   wave_c = (p1 >> 1) + (sub ? out_mid : out_zero);
      default:   wave_c = p1;
    endcase
  end

  // Stage 2: registered output and valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= out_mid;
      valid <= 1'b0;
    end else begin
      valid <= v1;
      if (v1) begin
        out <= wave_c;
      end
    end
  end

endmodule

// File: tb/tb_nco_wave.sv
// Scoreboard bench for nco_wave (default dsz=24, osz=12). Stimulus pushes the
// hand-computed expected sample and its due cycle; a forked monitor pops and
// compares whenever valid is seen.

module tb_nco_wave;

  localparam int unsigned DSZ = 24;
  localparam int unsigned OSZ = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic           ena;
  logic [DSZ-1:0] phs;
  logic [2:0]     wave_sel;
  logic [7:0]     pw;
  logic [OSZ-1:0] out;
  logic           valid;
  logic           sub;

  always #5 clk = ~clk;

  nco_wave #(.dsz(DSZ), .osz(OSZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .phs      (phs),
    .wave_sel (wave_sel),
    .pw       (pw),
    .out      (out),
    .valid    (valid),
    .sub      (sub)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] exp_q[$];
  int unsigned due_q[$];
  logic [22:0] lfsr_m;
  logic [11:0] last_exp;

  function automatic logic [22:0] lfsr_next(input logic [22:0] s);
    return {s[21:0], s[22] ^ s[17]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One sample strobe; e is the value expected on out two clocks later.
  task automatic smp(input logic [23:0] p, input logic [2:0] s, input logic [7:0] w,
                     input logic [11:0] e);
    ena      = 1'b1;
    phs      = p;
    wave_sel = s;
    pw       = w;
    exp_q.push_back(e);
    due_q.push_back(cyc + 2);
    lfsr_m   = lfsr_next(lfsr_m);
    last_exp = e;
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  task automatic idle(input int n);
    ena = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] e;
    logic [22:0] nx;
    logic [23:0] p;

    reset    = 1'b1;
    ena      = 1'b0;
    phs      = '0;
    wave_sel = '0;
    pw       = '0;
    lfsr_m   = 23'd1;
    last_exp = 12'h800;

    fork
      // Monitor: every valid must match the next queued sample, on time.
      forever begin
        @(negedge clk);
        if (!reset && valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(valid), 32'd0);
          end else begin
            chk("out", 32'(out), 32'(exp_q.pop_front()));
            chk("latency", cyc, due_q.pop_front());
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out", 32'(out), 32'h800);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sub", 32'(sub), 32'd0);

    // Single saw sample, then out holds
    smp(24'h123456, 3'd0, 8'h00, 12'h123);
    idle(4);
    chk("hold_out", 32'(out), 32'h123);
    chk("hold_valid", 32'(valid), 32'd0);

    // Triangle, applied at the wrap 0xF00000 -> 0x000000
    smp(24'hF00000, 3'd2, 8'h00, 12'hF00);
    smp(24'h000000, 3'd2, 8'h00, 12'h000);
    chk("sub_tri", 32'(sub), 32'd1);
    smp(24'h7FF000, 3'd2, 8'h00, 12'hFFE);
    smp(24'h800000, 3'd2, 8'h00, 12'hFFF);
    smp(24'hFFF000, 3'd2, 8'h00, 12'h001);

    // Sub square over four periods: out alternates per period
    for (int per = 0; per < 4; per++) begin
      for (int k = 0; k < 4; k++) begin
        p = 24'(k) << 22;
        e = (per % 2 == 1) ? 12'hFFF : 12'h000;
        smp(p, 3'd4, 8'h00, e);
      end
      chk("sub_ramp", 32'(sub), 32'(per % 2));
    end

    // Sub-2 square; equal consecutive phase is not a wrap
    smp(24'h000000, 3'd5, 8'h00, 12'hFFF);
    smp(24'h400000, 3'd5, 8'h00, 12'hFFF);
    smp(24'h000000, 3'd5, 8'h00, 12'hFFF);
    smp(24'h800000, 3'd5, 8'h00, 12'hFFF);
    smp(24'h800000, 3'd0, 8'h00, 12'hFFF);
    chk("sub_equal", 32'(sub), 32'd1);
    smp(24'h000000, 3'd0, 8'h00, 12'h000);

    // Select change mid-ramp takes effect only at the wrap
    smp(24'h400000, 3'd0, 8'h00, 12'h400);
    smp(24'h800000, 3'd1, 8'h00, 12'h800);
    smp(24'hC00000, 3'd1, 8'h00, 12'hC00);
    smp(24'h100000, 3'd1, 8'h00, 12'hEFF);
    smp(24'h200000, 3'd1, 8'h00, 12'hDFF);

    // Pulse with pw=0x80, then pw=0 at the next wrap
    smp(24'h7F0000, 3'd3, 8'h80, 12'h80F);
    smp(24'h000000, 3'd3, 8'h80, 12'hFFF);
    smp(24'h7F0000, 3'd3, 8'h80, 12'hFFF);
    smp(24'h800000, 3'd3, 8'h80, 12'h000);
    smp(24'h000000, 3'd3, 8'h00, 12'h000);
    smp(24'h400000, 3'd3, 8'h00, 12'h000);

    // Saw+sub mix, then an aliased large step counted as one wrap
    smp(24'h000000, 3'd7, 8'h00, 12'h000);
    smp(24'hFFF000, 3'd7, 8'h00, 12'h7FF);
    smp(24'h000000, 3'd7, 8'h00, 12'h800);
    smp(24'hFFF000, 3'd7, 8'h00, 12'hFFF);
    smp(24'hFFE000, 3'd7, 8'h00, 12'h7FF);
    chk("sub_alias", 32'(sub), 32'd0);

    // Sel 6 over 100 strobes with idle gaps
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 9) idle(2);
      p  = 24'(i) << 16;
      nx = lfsr_next(lfsr_m);
`ifdef NCO_WAVE_NOISE_EN
      e = nx[22:11];
`else
      e = p[23:12];
`endif
      smp(p, 3'd6, 8'h00, e);
    end
    chk("sub_noise", 32'(sub), 32'd1);
    idle(4);
    chk("noise_hold", 32'(out), 32'(last_exp));

    // Reset with a sample in flight: no valid may follow
    ena = 1'b1;
    phs = 24'h555000;
    @(posedge clk);
    #1;
    ena   = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    lfsr_m = 23'd1;
    chk("midrst_out", 32'(out), 32'h800);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_sub", 32'(sub), 32'd0);
    idle(3);

    // First strobe after reset never wraps (phs 0 vs phs_prev 0)
    smp(24'h000000, 3'd1, 8'h00, 12'h000);
    smp(24'h000000, 3'd1, 8'h00, 12'h000);
    chk("post_rst_sub", 32'(sub), 32'd0);

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    idle(2);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
